// File: rtl/gemm_stream_host.sv
// rtl/gemm_stream_host.sv - host-side src/dst stream engine for the GEMM batch controller
//
// One start pulse runs one job. A parameter load (mode_matw=1) streams PRM_WORDS words
// from the buffer RAM with matw=1. A batch compute streams nbatch*SRC_WORDS words with
// run=1 and writes every returned dst beat back to the RAM until the nbatch-th dst_last.
//
// Ports:
//   clk, reset (async, active-low)
//   start, mode_matw, nbatch, src_base, dst_base : job request, sampled while idle
//   dst_hold                                     : forces dst_ready low
//   busy, done                                   : job status, done is a one-cycle pulse
//   mem_re/mem_raddr/mem_rdata                   : RAM read port, 1-cycle read latency
//   mem_we/mem_waddr/mem_wdata                   : RAM write port (registered)
//   matw, run, last                              : qualifiers to the core
//   src_valid/src_data/src_ready                 : source stream to the core
//   dst_valid/dst_data/dst_last/dst_ready        : result stream from the core
module gemm_stream_host #(
  parameter int DW        = 32,
  parameter int AW        = 12,
  parameter int SRC_WORDS = 16,
  parameter int PRM_WORDS = 32,
  parameter int DST_WORDS = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode_matw,
  input  logic [7:0]    nbatch,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  input  logic          dst_hold,
  output logic          busy,
  output logic          done,
  output logic          mem_re,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic          matw,
  output logic          run,
  output logic          last,
  output logic          src_valid,
  output logic [DW-1:0] src_data,
  input  logic          src_ready,
  input  logic          dst_valid,
  input  logic [DW-1:0] dst_data,
  input  logic          dst_last,
  output logic          dst_ready
);

  if (SRC_WORDS < 1 || PRM_WORDS < 1 || DST_WORDS < 1) begin : g_bad_params
    $error("gemm_stream_host: word counts must be positive");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_PRM, ST_RUN, ST_FIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [AW-1:0] dst_base_q, dst_base_d;
  logic [AW-1:0] dcnt_q, dcnt_d;
  logic [7:0]    nb_q, nb_d;
  logic [7:0]    bdone_q, bdone_d;
  logic [13:0]   total_q, total_d;
  logic [13:0]   rd_cnt_q, rd_cnt_d;
  logic [13:0]   sent_q, sent_d;
  logic          inflight_q, inflight_d;
  logic [DW-1:0] fifo_q [2];
  logic [DW-1:0] fifo_d [2];
  logic          rd_ptr_q, rd_ptr_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          streaming;
  logic          pop, push;
  logic [2:0]    pend;
  logic          dst_fire;
  logic          final_beat;
  logic          batch_final;
  logic [7:0]    nb_eff;

  assign streaming = (state_q == ST_PRM) || (state_q == ST_RUN);
  assign src_valid = streaming && (cnt_q != 2'd0);
  assign src_data  = fifo_q[rd_ptr_q];
  // The core counts parameter beats on src_valid alone, so PRM never waits for src_ready.
  assign pop       = src_valid && ((state_q == ST_PRM) || src_ready);
  assign push      = streaming && inflight_q;
  // Words still held after this cycle's pop; counting the pop lets a read issue every
  // cycle while the core keeps accepting, without ever exceeding two stored words.
  assign pend      = {1'b0, cnt_q} - {2'b00, pop} + {2'b00, inflight_q};
  assign mem_re    = streaming && (pend < 3'd2) && (rd_cnt_q != total_q);
  assign mem_raddr = raddr_q;

  assign dst_ready   = (state_q == ST_RUN) && !dst_hold;
  assign dst_fire    = dst_valid && dst_ready;
  assign final_beat  = pop && (sent_q == total_q - 14'd1);
  assign batch_final = dst_fire && dst_last && (bdone_q == nb_q - 8'd1);
  assign nb_eff      = (nbatch == 8'd0) ? 8'd1 : nbatch;

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FIN);
  assign matw      = (state_q == ST_PRM);
  assign run       = (state_q == ST_RUN);
  assign last      = last_q;
  assign mem_we    = we_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;

  always_comb begin
    state_d    = state_q;
    raddr_d    = raddr_q;
    dst_base_d = dst_base_q;
    dcnt_d     = dcnt_q;
    nb_d       = nb_q;
    bdone_d    = bdone_q;
    total_d    = total_q;
    rd_cnt_d   = rd_cnt_q;
    sent_d     = sent_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = mode_matw ? ST_PRM : ST_RUN;
          raddr_d    = src_base;
          dst_base_d = dst_base;
          dcnt_d     = '0;
          nb_d       = nb_eff;
          bdone_d    = 8'd0;
          total_d    = mode_matw ? 14'(PRM_WORDS) : 14'(nb_eff) * 14'(SRC_WORDS);
          rd_cnt_d   = 14'd0;
          sent_d     = 14'd0;
        end
      end
      ST_PRM:  if (final_beat)  state_d = ST_FIN;
      ST_RUN:  if (batch_final) state_d = ST_FIN;
      default: state_d = ST_IDLE;
    endcase

    if (mem_re) begin
      raddr_d  = raddr_q + AW'(1);
      rd_cnt_d = rd_cnt_q + 14'd1;
    end
    if (pop) sent_d = sent_q + 14'd1;
    if (dst_fire) dcnt_d = dcnt_q + AW'(1);
    if (dst_fire && dst_last) bdone_d = bdone_q + 8'd1;
  end

  // Prefetch FIFO; flushed whenever the next state does not stream, which drops any
  // residual src words and the read still in flight when the job ends.
  always_comb begin
    fifo_d     = fifo_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    inflight_d = mem_re;
    if (state_d != ST_PRM && state_d != ST_RUN) begin
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      cnt_d      = 2'd0;
      inflight_d = 1'b0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = mem_rdata;
        wr_ptr_d         = !wr_ptr_q;
      end
      if (pop) rd_ptr_d = !rd_ptr_q;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_comb begin
    last_d  = (state_d == ST_RUN) && (last_q || final_beat);
    we_d    = dst_fire;
    waddr_d = dst_base_q + dcnt_q;
    wdata_d = dst_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      raddr_q    <= '0;
      dst_base_q <= '0;
      dcnt_q     <= '0;
      nb_q       <= 8'd0;
      bdone_q    <= 8'd0;
      total_q    <= 14'd0;
      rd_cnt_q   <= 14'd0;
      sent_q     <= 14'd0;
      inflight_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      last_q     <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      raddr_q    <= raddr_d;
      dst_base_q <= dst_base_d;
      dcnt_q     <= dcnt_d;
      nb_q       <= nb_d;
      bdone_q    <= bdone_d;
      total_q    <= total_d;
      rd_cnt_q   <= rd_cnt_d;
      sent_q     <= sent_d;
      inflight_q <= inflight_d;
      fifo_q     <= fifo_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_gemm_stream_host.sv
// tb/tb_gemm_stream_host.sv - self-checking bench for gemm_stream_host
module tb_gemm_stream_host;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode_matw = 1'b0;
  logic [7:0]  nbatch = 8'd0;
  logic [11:0] src_base = 12'd0;
  logic [11:0] dst_base = 12'd0;
  logic        dst_hold = 1'b0;
  logic        busy, done, mem_re, mem_we, matw, run, last, src_valid, dst_ready;
  logic [11:0] mem_raddr, mem_waddr;
  logic [31:0] mem_rdata, mem_wdata, src_data;
  logic        src_ready = 1'b0;
  logic        dst_valid = 1'b0;
  logic [31:0] dst_data = 32'd0;
  logic        dst_last = 1'b0;

  gemm_stream_host dut (
    .clk(clk), .reset(rst_n), .start(start), .mode_matw(mode_matw), .nbatch(nbatch),
    .src_base(src_base), .dst_base(dst_base), .dst_hold(dst_hold),
    .busy(busy), .done(done),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .matw(matw), .run(run), .last(last),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .dst_valid(dst_valid), .dst_data(dst_data), .dst_last(dst_last), .dst_ready(dst_ready)
  );

  always #5 clk = ~clk;

  // Buffer RAM: unwritten words read back as (addr - 0x100).
  bit [31:0] ram  [0:4095];
  bit        ramv [0:4095];
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= ramv[mem_raddr] ? ram[mem_raddr] : 32'(mem_raddr) - 32'h100;
    if (mem_we) begin
      ram[mem_waddr]  <= mem_wdata;
      ramv[mem_waddr] <= 1'b1;
    end
  end

  function automatic logic [31:0] ram_val(input logic [11:0] a);
    return ramv[a] ? ram[a] : 32'(a) - 32'h100;
  endfunction

  typedef struct {
    bit       mode;
    int       nbatch;
    int       sbase;
    int       dbase;
    bit [3:0] pat;
    int       hold_at;
    bit       restart;
    int       exp_beats;
    int       exp_writes;
    int       exp_span;
  } job_t;

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
  } wr_t;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bench-side job model
  bit          in_job = 1'b0;
  bit          cur_mode;
  int          cur_nb, cur_total, cur_hold, cur_id, cur_dbase;
  bit [3:0]    cur_pat;
  int          beats_done, dst_sent, issued, n_writes, first_beat, last_beat;
  int          ncyc = 0;
  int          rel = 0;
  bit          poke_dst = 1'b0;
  logic [31:0] sq[$];
  wr_t         wq[$];

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    bit fin, e_run, e_matw;
    wr_t w;
    if (rst_n) begin
      fin    = in_job && (cur_mode ? (beats_done == cur_total) : (dst_sent == cur_nb * 8));
      e_run  = in_job && !cur_mode && !fin;
      e_matw = in_job && cur_mode && !fin;
      chk("busy", 32'(busy), 32'(in_job));
      chk("done", 32'(done), 32'(fin));
      chk("matw", 32'(matw), 32'(e_matw));
      chk("run", 32'(run), 32'(e_run));
      chk("last", 32'(last), 32'(e_run && beats_done == cur_total));
      chk("dst_ready", 32'(dst_ready), 32'(e_run && !dst_hold));
      if (!in_job || fin) chk("src_valid_quiet", 32'(src_valid), 32'd0);
      if (src_valid && (cur_mode || src_ready)) begin
        if (sq.size() == 0) chk("src_extra_beat", 32'd1, 32'd0);
        else chk("src_data", src_data, sq.pop_front());
        if (beats_done == 0) first_beat = ncyc;
        last_beat = ncyc;
        beats_done++;
      end
      if (mem_re) issued++;
      if (in_job) chk("pending_le_2", 32'(issued - beats_done <= 2), 32'd1);
      if (mem_we) begin
        n_writes++;
        if (wq.size() == 0) chk("write_unexpected", 32'd1, 32'd0);
        else begin
          w = wq.pop_front();
          chk("waddr", 32'(mem_waddr), 32'(w.a));
          chk("wdata", mem_wdata, w.d);
        end
      end
      if (dst_valid && dst_ready) begin
        w.a = 12'(cur_dbase + dst_sent);
        w.d = dst_data;
        wq.push_back(w);
        dst_sent++;
      end
      chk("write_latency", 32'(wq.size() <= 1), 32'd1);
      if (fin) in_job = 1'b0;
    end
    ncyc++;
  end

  // Core model and backpressure driver, just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (in_job) rel++; else rel = 0;
    src_ready = in_job ? cur_pat[rel % 4] : 1'b0;
    dst_hold  = in_job && cur_hold >= 0 && rel >= cur_hold && rel < cur_hold + 5;
    if (in_job && !cur_mode && dst_sent < (beats_done / 16) * 8 && dst_sent < cur_nb * 8) begin
      dst_valid = 1'b1;
      dst_data  = 32'hD000_0000 + 32'(cur_id << 12) + 32'(dst_sent);
      dst_last  = (dst_sent % 8) == 7;
    end else begin
      dst_valid = poke_dst;
      dst_data  = 32'hBAD0_0000;
      dst_last  = poke_dst;
    end
  end

  task automatic launch(input job_t j, input int id);
    cur_mode   = j.mode;
    cur_nb     = (j.nbatch == 0) ? 1 : j.nbatch;
    cur_total  = j.mode ? 32 : cur_nb * 16;
    cur_pat    = j.pat;
    cur_hold   = j.hold_at;
    cur_id     = id;
    cur_dbase  = j.dbase;
    beats_done = 0; dst_sent = 0; issued = 0; n_writes = 0;
    first_beat = 0; last_beat = 0;
    sq.delete(); wq.delete();
    for (int i = 0; i < cur_total; i++) sq.push_back(ram_val(12'(j.sbase + i)));
    @(posedge clk); #1;
    mode_matw = j.mode;
    nbatch    = 8'(j.nbatch);
    src_base  = 12'(j.sbase);
    dst_base  = 12'(j.dbase);
    start     = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    in_job = 1'b1;
  endtask

  task automatic run_job(input job_t j, input int id);
    launch(j, id);
    if (j.restart) begin
      repeat (5) @(posedge clk);
      #1;
      mode_matw = ~j.mode; nbatch = 8'd7; src_base = 12'h555; dst_base = 12'h111;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < 3000 && in_job; i++) @(negedge clk);
    #1;
    if (in_job) begin
      chk("job_timeout", 32'd1, 32'd0);
      in_job = 1'b0;
    end
    chk("beats", 32'(beats_done), 32'(j.exp_beats));
    chk("writes", 32'(n_writes), 32'(j.exp_writes));
    chk("src_left", 32'(sq.size()), 32'd0);
    chk("wr_left", 32'(wq.size()), 32'd0);
    if (j.exp_span >= 0) chk("beat_span", 32'(last_beat - first_beat), 32'(j.exp_span));
    @(negedge clk);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  job_t jobs[5];
  job_t jr;

  initial begin
    jobs[0] = '{1'b1, 0, 'h100, 'h000, 4'b0000, -1, 1'b0, 32, 0, 31};
    jobs[1] = '{1'b0, 1, 'h100, 'h800, 4'b1111, -1, 1'b0, 16, 8, 15};
    jobs[2] = '{1'b0, 2, 'h180, 'h900, 4'b1001, -1, 1'b1, 32, 16, -1};
    jobs[3] = '{1'b0, 3, 'h300, 'hA00, 4'b1111, 22, 1'b0, 48, 24, 47};
    jobs[4] = '{1'b0, 0, 'h400, 'hFFC, 4'b1111, -1, 1'b0, 16, 8, 15};

    repeat (3) @(posedge clk);
    #3;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_src_valid", 32'(src_valid), 32'd0);
    chk("reset_mem_re", 32'(mem_re), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    rst_n = 1'b1;

    // dst traffic while idle must be ignored
    n_writes = 0;
    @(posedge clk); #1;
    poke_dst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    poke_dst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("idle_dst_writes", 32'(n_writes), 32'd0);

    for (int k = 0; k < 5; k++) run_job(jobs[k], k);

    chk("wrap_ram_fff", ram[12'hFFF], 32'hD000_4003);
    chk("wrap_ram_000", ram[12'h000], 32'hD000_4004);

    // Reset during RUN beat 7, then a clean rerun.
    launch(jobs[1], 5);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (beats_done >= 7) break;
    end
    chk("reached_beat7", 32'(beats_done), 32'd7);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_matw", 32'(matw), 32'd0);
    chk("rst_run", 32'(run), 32'd0);
    chk("rst_last", 32'(last), 32'd0);
    chk("rst_src_valid", 32'(src_valid), 32'd0);
    chk("rst_dst_ready", 32'(dst_ready), 32'd0);
    in_job = 1'b0;
    sq.delete(); wq.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    jr = jobs[1];
    jr.dbase = 'hB00;
    run_job(jr, 6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
